// File: rtl/key_code_collector.sv
// key_code_collector: gathers CODE_LENGTH one-hot key presses into a code word.
// A partial entry is discarded after TIMEOUT_CYCLES idle cycles. A complete
// code is held until the consumer takes it.
//
// Handshake: code_valid is high for as long as a complete code is held. The
// code transfers on a rising edge where code_valid and code_ready are both high.
// code and digit_count stay stable until that transfer. code_ready has no effect
// while code_valid is low.
module key_code_collector #(
    parameter int CODE_LENGTH    = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [3:0]                 posedge_key,
    input  logic                       code_ready,
    output logic [2*CODE_LENGTH-1:0]   code,
    output logic                       code_valid,
    output logic [3:0]                 digit_count,
    output logic                       entry_active,
    output logic                       timeout,
    output logic                       invalid_press
);

    localparam int CODE_W = 2 * CODE_LENGTH;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       FULL_COUNT   = 4'(CODE_LENGTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [3:0]          count_q, count_d;
    logic [CNT_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic                timeout_q, timeout_d;
    logic                invalid_q, invalid_d;

    logic                key_single;
    logic                key_multi;
    logic [1:0]          key_digit;
    logic [CODE_W-1:0]   code_shifted;
    logic [3:0]          count_inc;

    // Classify this cycle's key pulses: none, exactly one (with its digit), or several.
    always_comb begin
        key_single = 1'b0;
        key_multi  = 1'b0;
        key_digit  = 2'd0;
        case (posedge_key)
            4'b0000: ;
            4'b0001: begin key_single = 1'b1; key_digit = 2'd0; end
            4'b0010: begin key_single = 1'b1; key_digit = 2'd1; end
            4'b0100: begin key_single = 1'b1; key_digit = 2'd2; end
            4'b1000: begin key_single = 1'b1; key_digit = 2'd3; end
            default: key_multi = 1'b1;
        endcase
    end

    assign code_shifted = {code_q[CODE_W-3:0], key_digit};
    assign count_inc    = count_q + 4'd1;

    // Next-state and datapath decisions. In ENTRY a valid press takes priority
    // over the timeout. A multi-key press freezes the entry for that cycle.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        count_d    = count_q;
        idle_cnt_d = idle_cnt_q;
        timeout_d  = 1'b0;
        invalid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_single) begin
                    state_d    = ENTRY;
                    code_d     = code_shifted;
                    count_d    = 4'd1;
                    idle_cnt_d = '0;
                end else if (key_multi) begin
                    invalid_d = 1'b1;
                end
            end
            ENTRY: begin
                if (key_single) begin
                    code_d     = code_shifted;
                    count_d    = count_inc;
                    idle_cnt_d = '0;
                    if (count_inc == FULL_COUNT) begin
                        state_d = HOLD;
                    end
                end else if (key_multi) begin
                    invalid_d = 1'b1;
                end else if (idle_cnt_q == CNT_TERMINAL) begin
                    state_d    = IDLE;
                    code_d     = '0;
                    count_d    = 4'd0;
                    idle_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (code_ready) begin
                    state_d    = IDLE;
                    code_d     = '0;
                    count_d    = 4'd0;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                code_d     = '0;
                count_d    = 4'd0;
                idle_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset clears every digit and pulse at once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            code_q     <= '0;
            count_q    <= 4'd0;
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            count_q    <= count_d;
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
            invalid_q  <= invalid_d;
        end
    end

    assign code          = code_q;
    assign digit_count   = count_q;
    assign code_valid    = (state_q == HOLD);
    assign entry_active  = (state_q == ENTRY);
    assign timeout       = timeout_q;
    assign invalid_press = invalid_q;

endmodule

// File: doc/key_code_collector.md
KEY_CODE_COLLECTOR -- requirements
Module: key_code_collector

Interface
REQ-001 Parameter CODE_LENGTH, default 4, number of key digits per code (SHALL be 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000000, idle cycles allowed between presses before the partial entry is discarded (SHALL be >= 2).
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port posedge_key  input  4  one-cycle key press pulses, one bit per key.
REQ-006 Port code_ready  input  1  consumer accepts code when high with code_valid.
REQ-007 Port code  output  2*CODE_LENGTH  collected digits, most recent digit in bits [1:0].
REQ-008 Port code_valid  output  1  complete code held for consumer.
REQ-009 Port digit_count  output  4  number of digits accepted in current entry.
REQ-010 Port entry_active  output  1  high while in ENTRY state.
REQ-011 Port timeout  output  1  one-cycle pulse when a partial entry is discarded by timeout.
REQ-012 Port invalid_press  output  1  one-cycle pulse when a multi-key press is rejected.

Function
REQ-013 States SHALL be IDLE, ENTRY, HOLD; entry_active = (state == ENTRY).
REQ-014 Valid press: posedge_key exactly one-hot; digit encoding key[0]->0, key[1]->1, key[2]->2, key[3]->3.
REQ-015 Invalid press: two or more bits of posedge_key set in one cycle in IDLE or ENTRY; SHALL pulse invalid_press next cycle, not alter code, digit_count, state or timeout counter.
REQ-016 IDLE + valid press -> ENTRY; code <= {code[2*CODE_LENGTH-3:0], digit}; digit_count <= 1; timeout counter <= 0.
REQ-017 ENTRY + valid press: shift digit in as REQ-016, digit_count increments, timeout counter cleared.
REQ-018 ENTRY + valid press making digit_count == CODE_LENGTH -> HOLD; code_valid high from the following cycle.
REQ-019 ENTRY without valid press: timeout counter increments by 1 per cycle.
REQ-020 ENTRY when counter reaches TIMEOUT_CYCLES-1 with no valid press that cycle -> IDLE; code <= 0, digit_count <= 0, timeout pulses one cycle.
REQ-021 Valid press in the same cycle as counter terminal value SHALL win; no timeout.
REQ-022 HOLD: code_valid held high, code and digit_count stable until code_ready sampled high.
REQ-023 HOLD + code_ready -> IDLE next cycle; code_valid low, code <= 0, digit_count <= 0.
REQ-024 All posedge_key activity in HOLD SHALL be ignored (no shift, no invalid_press).
REQ-025 code_ready outside HOLD SHALL have no effect.
REQ-026 Timeout counter width SHALL be ceil(log2(TIMEOUT_CYCLES)) bits; no wrap beyond terminal value.
REQ-027 Latency: press pulse at edge N -> code/digit_count updated after edge N; final digit -> code_valid high after same edge.

Reset
REQ-028 resetn low SHALL immediately force state IDLE, code 0, code_valid 0, digit_count 0, timeout counter 0, timeout 0, invalid_press 0.
REQ-029 Reset asserted mid-entry or in HOLD SHALL discard all digits; first press after release starts a new entry.
REQ-030 posedge_key sampled in the first edge after resetn rises SHALL be processed normally.

Verification (CODE_LENGTH=4, TIMEOUT_CYCLES=8)
REQ-031 Presses 4'b0010, 4'b1000, 4'b0001, 4'b0100 on separate cycles -> code = 8'b01_11_00_10, code_valid high, digit_count 4; hold code_ready low 5 cycles -> unchanged; code_ready high -> IDLE, code 0.
REQ-032 Press 4'b0001 then 8 idle cycles -> timeout pulse on cycle 8, digit_count 0, entry_active low.
REQ-033 Press 4'b0011 in IDLE -> invalid_press one cycle, state IDLE, digit_count 0; in ENTRY with 2 digits -> digit_count remains 2.
REQ-034 Valid press on the counter terminal cycle -> no timeout, digit_count increments, counter restarts.
REQ-035 Presses during HOLD -> code unchanged; resetn pulsed low mid-entry after 3 digits -> all outputs 0 asynchronously, next press gives digit_count 1.
